// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
//
// Parametrised up/down event/timer counter with a programmable upper limit,
// parallel load, count enable and three boundary behaviours (wrap, saturate,
// one-shot). The count range is always 0..limit.
//
// Optional feature macro: UDC_PRESCALER_EN
//   When defined, an enable prescaler makes only every PRESCALE-th en-high
//   cycle (in RUN) a real step. When undefined there is no prescaler logic and
//   PRESCALE is only range-checked.
//
// Parameters:
//   WIDTH      counter width in bits (>= 2)
//   PRESCALE   enable prescale ratio (>= 2), used with UDC_PRESCALER_EN only
//
// Ports:
//   clk         in   rising-edge clock for all state
//   reset       in   asynchronous, active-high reset
//   en          in   count enable
//   up_down     in   0 = count up, 1 = count down
//   load        in   synchronous parallel load (highest priority)
//   load_val    in   value to load, clamped to limit
//   limit       in   upper bound of the count range
//   mode        in   00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   clear_done  in   releases the one-shot DONE state
//   counter     out  current count (registered)
//   tc          out  one-cycle terminal-count pulse after a boundary step
//   done        out  high while the one-shot FSM is in DONE; this is the
//                    registered FSM state bit, so it doubles as the FSM debug view
//   ovf         out  sticky flag, set by a wrap, cleared by load or reset
//
// Handshake: there is no valid/ready pairing; every input is sampled on each
// rising clk edge and all outputs update on that same edge.
// -----------------------------------------------------------------------------
module updown_counter_param #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic [1:0]       mode,
    input  logic             clear_done,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             done,
    output logic             ovf
);

    if (WIDTH < 2 || PRESCALE < 2) begin : g_param_check
        $error("updown_counter_param: WIDTH and PRESCALE must both be >= 2");
    end

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             take_step;

`ifdef UDC_PRESCALER_EN
    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PSC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]  PSC_ONE  = PW'(1);

    logic [PW-1:0] psc_q, psc_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tc_d      = 1'b0;
        ovf_d     = ovf_q;
        take_step = 1'b0;
`ifdef UDC_PRESCALER_EN
        psc_d     = psc_q;
`endif

        if (load) begin
            cnt_d   = (load_val > limit) ? limit : load_val;
            ovf_d   = 1'b0;
            state_d = ST_RUN;
`ifdef UDC_PRESCALER_EN
            psc_d   = '0;
`endif
        end else if (clear_done) begin
            // Release only; any step waits for the following edge.
            state_d = ST_RUN;
        end else if (en && state_q == ST_RUN) begin
`ifdef UDC_PRESCALER_EN
            if (psc_q == PSC_LAST) begin
                psc_d     = '0;
                take_step = 1'b1;
            end else begin
                psc_d = psc_q + PSC_ONE;
            end
`else
            take_step = 1'b1;
`endif
        end

        if (take_step) begin
            if (!up_down) begin
                if (cnt_q < limit) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    // At or above limit (limit may have been lowered): boundary.
                    tc_d = 1'b1;
                    case (mode)
                        2'b01: cnt_d = limit;
                        2'b10: begin
                            cnt_d   = limit;
                            state_d = ST_DONE;
                        end
                        default: begin
                            cnt_d = CNT_ZERO;
                            ovf_d = 1'b1;
                        end
                    endcase
                end
            end else begin
                if (cnt_q > limit) begin
                    // Pull back into range; not a boundary event.
                    cnt_d = limit;
                end else if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    tc_d = 1'b1;
                    case (mode)
                        2'b01: cnt_d = CNT_ZERO;
                        2'b10: begin
                            cnt_d   = CNT_ZERO;
                            state_d = ST_DONE;
                        end
                        default: begin
                            cnt_d = limit;
                            ovf_d = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef UDC_PRESCALER_EN
            psc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
`ifdef UDC_PRESCALER_EN
            psc_q   <= psc_d;
`endif
        end
    end

    assign counter = cnt_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_updown_counter_param.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_param
//
// Directed scenarios followed by a randomised run, all checked against a
// behavioural model of the counter's rules held in plain variables.
// -----------------------------------------------------------------------------
module tb_updown_counter_param;

    localparam int W  = 4;
    localparam int PS = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         en, up_down, load, clear_done;
    logic [W-1:0] load_val, limit;
    logic [1:0]   mode;
    logic [W-1:0] counter;
    logic         tc, done, ovf;

    updown_counter_param #(.WIDTH(W), .PRESCALE(PS)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up_down    (up_down),
        .load       (load),
        .load_val   (load_val),
        .limit      (limit),
        .mode       (mode),
        .clear_done (clear_done),
        .counter    (counter),
        .tc         (tc),
        .done       (done),
        .ovf        (ovf)
    );

    // ---------------- reference model ----------------
    int unsigned m_cnt;
    bit          m_tc, m_done, m_ovf;
    int unsigned m_psc;

    int vectors    = 0;
    int miscompares = 0;

    function automatic void model_reset();
        m_cnt  = 0;
        m_tc   = 0;
        m_done = 0;
        m_ovf  = 0;
        m_psc  = 0;
    endfunction

    // One clock edge of the counter's rules, evaluated from the inputs
    // currently being driven.
    function automatic void model_edge();
        int unsigned lim;
        bit          stepping;
        bit          wraps;
        lim  = limit;
        m_tc = 0;
        if (load) begin
            m_cnt  = (load_val < lim) ? load_val : lim;
            m_ovf  = 0;
            m_done = 0;
            m_psc  = 0;
        end else if (clear_done) begin
            m_done = 0;
        end else if (en && !m_done) begin
            stepping = 1;
`ifdef UDC_PRESCALER_EN
            if (m_psc == PS - 1) m_psc = 0;
            else begin
                m_psc    = m_psc + 1;
                stepping = 0;
            end
`endif
            if (stepping) begin
                wraps = (mode == 2'b00) || (mode == 2'b11);
                if (!up_down && m_cnt < lim) begin
                    m_cnt = m_cnt + 1;
                end else if (up_down && m_cnt > lim) begin
                    m_cnt = lim;
                end else if (up_down && m_cnt > 0) begin
                    m_cnt = m_cnt - 1;
                end else begin
                    // Boundary reached: wrap jumps to the opposite end,
                    // saturate/one-shot pin to the end being approached.
                    m_tc = 1;
                    if (wraps) begin
                        m_cnt = up_down ? lim : 0;
                        m_ovf = 1;
                    end else begin
                        m_cnt = up_down ? 0 : lim;
                        if (mode == 2'b10) m_done = 1;
                    end
                end
            end
        end
    endfunction

    // ---------------- scoreboard checks ----------------
    task automatic check_all(input string tag);
        vectors++;
        assert (counter === W'(m_cnt)) else begin
            miscompares++;
            $error("FAIL %s counter got %0d exp %0d", tag, counter, m_cnt);
        end
        vectors++;
        assert (tc === m_tc) else begin
            miscompares++;
            $error("FAIL %s tc got %b exp %b", tag, tc, m_tc);
        end
        vectors++;
        assert (done === m_done) else begin
            miscompares++;
            $error("FAIL %s done got %b exp %b", tag, done, m_done);
        end
        vectors++;
        assert (ovf === m_ovf) else begin
            miscompares++;
            $error("FAIL %s ovf got %b exp %b", tag, ovf, m_ovf);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; drives inputs, advances the model,
    // waits one edge and checks the registered outputs.
    task automatic drive(input bit e, input bit ud, input bit ld,
                         input logic [W-1:0] lv, input logic [W-1:0] lim,
                         input logic [1:0] md, input bit cd, input string tag);
        en         = e;
        up_down    = ud;
        load       = ld;
        load_val   = lv;
        limit      = lim;
        mode       = md;
        clear_done = cd;
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Watchdog: the whole run is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] r_lim, r_lv;
        logic [1:0]   r_mode;
        bit           r_ud, r_en, r_ld, r_cd;

        reset = 1'b1;
        en = 0; up_down = 0; load = 0; clear_done = 0;
        load_val = '0; limit = '0; mode = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_values");
        reset = 1'b0;

        // Wrap mode, limit 9, count up 12 cycles: 1..9,0,1,2.
        for (int i = 0; i < 12; i++) drive(1, 0, 0, 4'd0, 4'd9, 2'b00, 0, "wrap_up");

        // Saturate, load 2, count down into the floor.
        drive(0, 1, 1, 4'd2, 4'd9, 2'b01, 0, "sat_load");
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 4'd0, 4'd9, 2'b01, 0, "sat_down");

        // One-shot from 7 up to 9, boundary, then held in DONE.
        drive(0, 0, 1, 4'd7, 4'd9, 2'b10, 0, "os_load");
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 4'd0, 4'd9, 2'b10, 0, "os_up");
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 4'd0, 4'd9, 2'b10, 0, "os_hold");
        drive(1, 0, 0, 4'd0, 4'd9, 2'b00, 0, "os_mode_chg");
        drive(1, 0, 0, 4'd0, 4'd9, 2'b10, 1, "os_clear");
        drive(1, 0, 0, 4'd0, 4'd9, 2'b10, 0, "os_rebound");

        // Limit lowered below the count: wrap then saturate.
        drive(0, 0, 1, 4'd8, 4'd9, 2'b00, 0, "lim_load_w");
        drive(1, 0, 0, 4'd0, 4'd5, 2'b00, 0, "lim_low_wrap");
        drive(0, 0, 1, 4'd8, 4'd9, 2'b01, 0, "lim_load_s");
        drive(1, 0, 0, 4'd0, 4'd5, 2'b01, 0, "lim_low_sat");
        drive(0, 0, 1, 4'd8, 4'd9, 2'b01, 0, "lim_load_d");
        drive(1, 1, 0, 4'd0, 4'd5, 2'b01, 0, "lim_low_down");

        // Load with en in the same cycle, clamped to limit, no step.
        drive(1, 0, 1, 4'd12, 4'd9, 2'b00, 0, "load_clamp");

        // limit 0: every step is a boundary.
        drive(0, 0, 1, 4'd3, 4'd0, 2'b00, 0, "lim0_load");
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 4'd0, 4'd0, 2'b00, 0, "lim0_step");

        // Count from 3 to 6 (the model tracks prescaling), then async reset.
        drive(0, 0, 1, 4'd3, 4'd9, 2'b00, 0, "ar_load");
        while (m_cnt != 6) drive(1, 0, 0, 4'd0, 4'd9, 2'b00, 0, "ar_count");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 4'd0, 4'd9, 2'b00, 0, "post_reset");

        // Randomised traffic.
        r_lim  = 4'd9;
        r_mode = 2'b00;
        r_ud   = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) r_lim  = W'($urandom_range(0, 15));
            if ($urandom_range(0, 14) == 0) r_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) r_ud   = ~r_ud;
            r_en = ($urandom_range(0, 3) != 0);
            r_ld = ($urandom_range(0, 15) == 0);
            r_cd = ($urandom_range(0, 11) == 0);
            r_lv = W'($urandom_range(0, 15));
            drive(r_en, r_ud, r_ld, r_lv, r_lim, r_mode, r_cd, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
